// File: rtl/led_sequencer.sv
// LED pattern sequencer: debounced mode button, prescaled step tick,
// and four LED patterns (OFF, COUNT, SCAN, BLINK).
//
// A button press is accepted only while "armed". The debouncer leaves
// reset with stable=1, but a button already held low at that point must not
// count as a press. So the sequencer arms only after it has seen the button
// high. Leaving reset, that means stable and the synchronized level both stay
// high for DEBOUNCE+2 cycles, which covers the two synchronizer reset
// samples. After that, each accepted release re-arms it.
//
// The mode output is the FSM state register itself.
module led_sequencer #(
  parameter int unsigned STEP_DIV = 3125000,
  parameter int unsigned DEBOUNCE = 250000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_n,
  input  logic       run,
  output logic [7:0] led,
  output logic [1:0] mode,
  output logic       step
);

  localparam int PW = $clog2(STEP_DIV);
  localparam int DW = $clog2(DEBOUNCE);
  localparam int AW = $clog2(DEBOUNCE + 2);
  localparam logic [PW-1:0] PS_LAST  = PW'(STEP_DIV - 1);
  localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE - 1);
  localparam logic [AW-1:0] ARM_LAST = AW'(DEBOUNCE + 1);

  typedef enum logic [1:0] {
    M_OFF   = 2'd0,
    M_COUNT = 2'd1,
    M_SCAN  = 2'd2,
    M_BLINK = 2'd3
  } mode_t;

  logic          sync1_q, sync1_d, sync2_q, sync2_d;
  logic          stable_q, stable_d;
  logic [DW-1:0] db_cnt_q, db_cnt_d;
  logic [AW-1:0] arm_cnt_q, arm_cnt_d;
  logic          armed_q, armed_d;
  logic          press_q, press_d;
  logic [PW-1:0] ps_cnt_q, ps_cnt_d;
  logic          tick;
  logic          step_q, step_d;
  mode_t         mode_q, mode_d;
  logic [7:0]    pat_q, pat_d;
  logic          dir_up_q, dir_up_d;

  // Synchronizer, debouncer and press-event detection.
  always_comb begin
    sync1_d   = btn_n;
    sync2_d   = sync1_q;
    stable_d  = stable_q;
    db_cnt_d  = '0;
    arm_cnt_d = '0;
    armed_d   = armed_q;
    press_d   = 1'b0;
    if (sync2_q != stable_q) begin
      if (db_cnt_q == DB_LAST) begin
        stable_d = sync2_q;
        if (!sync2_q) begin
          press_d = armed_q;
          armed_d = 1'b0;
        end else begin
          armed_d = 1'b1;
        end
      end else begin
        db_cnt_d = db_cnt_q + DW'(1);
      end
    end else if (stable_q && !armed_q) begin
      if (arm_cnt_q == ARM_LAST) armed_d = 1'b1;
      else arm_cnt_d = arm_cnt_q + AW'(1);
    end
  end

  // Prescaler, mode FSM and pattern generator; a press overrides a same-cycle tick.
  always_comb begin
    tick     = run && (ps_cnt_q == PS_LAST);
    ps_cnt_d = ps_cnt_q;
    mode_d   = mode_q;
    pat_d    = pat_q;
    dir_up_d = dir_up_q;
    step_d   = tick && !press_q;
    if (press_q) begin
      ps_cnt_d = '0;
      mode_d   = mode_t'(mode_q + 2'd1);
      dir_up_d = 1'b1;
      pat_d    = (mode_d == M_SCAN) ? 8'h01 : 8'h00;
    end else if (run) begin
      ps_cnt_d = tick ? '0 : ps_cnt_q + PW'(1);
      if (tick) begin
        case (mode_q)
          M_COUNT: pat_d = pat_q + 8'd1;
          M_SCAN: begin
            if (dir_up_q) begin
              if (pat_q == 8'h80) begin
                pat_d    = 8'h40;
                dir_up_d = 1'b0;
              end else begin
                pat_d = pat_q << 1;
              end
            end else begin
              if (pat_q == 8'h01) begin
                pat_d    = 8'h02;
                dir_up_d = 1'b1;
              end else begin
                pat_d = pat_q >> 1;
              end
            end
          end
          M_BLINK: pat_d = ~pat_q;
          default: pat_d = 8'h00;
        endcase
      end
    end
  end

  // All state registers, asynchronously reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      stable_q  <= 1'b1;
      db_cnt_q  <= '0;
      arm_cnt_q <= '0;
      armed_q   <= 1'b0;
      press_q   <= 1'b0;
      ps_cnt_q  <= '0;
      step_q    <= 1'b0;
      mode_q    <= M_COUNT;
      pat_q     <= 8'h00;
      dir_up_q  <= 1'b1;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      stable_q  <= stable_d;
      db_cnt_q  <= db_cnt_d;
      arm_cnt_q <= arm_cnt_d;
      armed_q   <= armed_d;
      press_q   <= press_d;
      ps_cnt_q  <= ps_cnt_d;
      step_q    <= step_d;
      mode_q    <= mode_d;
      pat_q     <= pat_d;
      dir_up_q  <= dir_up_d;
    end
  end

  assign led  = pat_q;
  assign mode = mode_q;
  assign step = step_q;

endmodule

// File: doc/led_sequencer.md
LED_SEQUENCER -- requirements
Module: led_sequencer

Interface
REQ-001 Parameter STEP_DIV, default 3125000, is the number of clk cycles per pattern step (8 Hz at 25 MHz); legal range 2..2^24.
REQ-002 Parameter DEBOUNCE, default 250000, is the number of consecutive clk cycles a changed button level must hold to be accepted (10 ms at 25 MHz); legal range 2..2^20.
REQ-003 Port clk, input, 1 bit: single 25 MHz clock; all state changes on its rising edge.
REQ-004 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port btn_n, input, 1 bit: mode-advance pushbutton, active-low, asynchronous to clk, bouncy.
REQ-006 Port run, input, 1 bit: 1 = pattern advances; 0 = pattern and prescaler freeze.
REQ-007 Port led, output, 8 bits: registered LED pattern, bit 0 = led0.
REQ-008 Port mode, output, 2 bits: current mode (0 OFF, 1 COUNT, 2 SCAN, 3 BLINK).
REQ-009 Port step, output, 1 bit: one-cycle pulse on every accepted prescaler tick.

Function
REQ-010 btn_n SHALL pass through a 2-flop synchronizer; both flops reset to 1.
REQ-011 Debouncer: stable level (reset 1) SHALL take the synchronized level once it has differed from stable for DEBOUNCE consecutive cycles; any cycle where they match clears the debounce counter.
REQ-012 Press event SHALL be a single-cycle internal pulse on a stable 1->0 transition; release (0->1) generates no event.
REQ-013 Holding the button SHALL produce exactly one press event regardless of hold length.
REQ-014 Prescaler SHALL count 0..STEP_DIV-1 while run=1, asserting tick in the cycle the count equals STEP_DIV-1 and wrapping to 0 on the next edge.
REQ-015 While run=0, prescaler count SHALL hold and tick SHALL be 0; press events are still accepted.
REQ-016 step SHALL equal tick, registered: high for exactly the one cycle after the tick cycle, i.e. aligned with the led update.
REQ-017 Mode FSM SHALL advance on each press event: OFF->COUNT->SCAN->BLINK->OFF.
REQ-018 In the cycle after a press event: mode takes the new value, prescaler count clears to 0, and the pattern loads its initial value (COUNT 0x00, SCAN 0x01 with direction up, BLINK 0x00, OFF 0x00).
REQ-019 If a press event and a tick fall in the same cycle, the press event SHALL win and the tick SHALL be discarded (no step pulse).
REQ-020 COUNT: each tick increments the pattern by 1, modulo 256 (0xFF->0x00).
REQ-021 SCAN, direction up: tick shifts left; at pattern 0x80 the tick instead loads 0x40 and sets direction down.
REQ-022 SCAN, direction down: tick shifts right; at pattern 0x01 the tick instead loads 0x02 and sets direction up; exactly one led bit is lit at all times.
REQ-023 BLINK: each tick inverts the pattern (0x00<->0xFF).
REQ-024 OFF: pattern SHALL remain 0x00; ticks still pulse step.
REQ-025 led SHALL be driven directly from the pattern register; no combinational path from any input to led.

Reset
REQ-026 Asserting rst_n low SHALL immediately (without clk) force: mode=COUNT, led=0x00, step=0, SCAN direction up, prescaler 0, debounce counter 0, stable and synchronizer flops 1.
REQ-027 Reset mid-debounce or mid-step SHALL discard the partial count; no press event or tick is generated on deassertion even if btn_n is low then (a press is only recognised after a release is accepted).
REQ-028 After rst_n deasserts, first tick SHALL occur STEP_DIV cycles later if run=1.

Verification (STEP_DIV=4, DEBOUNCE=3)
REQ-029 Reset, run=1, btn_n=1, 20 cycles -> mode=1, led 0x00,0x01,0x02,0x03,0x04 with changes every 4 cycles, step pulse with each change.
REQ-030 Pulse btn_n low 2 cycles, then a stable low 10 cycles -> the glitch is ignored, exactly one press event, mode 1->2, led=0x01, prescaler restarted.
REQ-031 SCAN mode, run=1, 16 ticks -> led 02,04,08,10,20,40,80,40,20,10,08,04,02,01,02,04.
REQ-032 Mode BLINK, run toggled 0 for 10 cycles mid-count -> led and prescaler frozen, no step; resumes with remaining count; led alternates 0xFF/0x00.
REQ-033 Press event forced coincident with tick in COUNT at led=0x05 -> mode=2, led=0x01, no step that cycle.
REQ-034 Assert rst_n low asynchronously between clk edges while in BLINK at 0xFF with btn_n held low -> led=0x00, mode=1 immediately; after release of rst_n no mode change until btn_n goes high and low again.
